// File: rtl/maxpool_ctrl.sv
// maxpool_ctrl: sequencer for a 2x2 / stride-2 max-pool compare unit.
// Streams window pixel pairs out of a dual-read-port RAM and writes each window maximum row-major.
module maxpool_ctrl #(
    parameter int BD = 18,
    parameter int AW = 12,
    parameter int DW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] cfg_w,
    input  logic [DW-1:0] cfg_h,
    input  logic [AW-1:0] cfg_src_base,
    input  logic [AW-1:0] cfg_dst_base,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] raddr0,
    output logic [AW-1:0] raddr1,
    output logic          mpen,
    output logic          wincnt,
    input  logic [BD-1:0] d,
    output logic          wr_en,
    output logic [AW-1:0] waddr,
    output logic [BD-1:0] wdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TOP   = 3'd1,
        S_BOT   = 3'd2,
        S_DRAIN = 3'd3,
        S_EMPTY = 3'd4
    } state_t;

    localparam logic [DW-1:0] ZERO_D = {DW{1'b0}};
    localparam logic [DW-1:0] ONE_D  = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ONE_A  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] TWO_A  = {{(AW-2){1'b0}}, 2'b10};

    state_t        state_r;
    state_t        state_nx_s;

    logic [DW-1:0] w_r;
    logic [DW-1:0] ow_r;
    logic [DW-1:0] oh_r;
    logic [DW-1:0] col_r;
    logic [DW-1:0] row_r;
    logic [AW-1:0] cur_top_r;
    logic [AW-1:0] row_base_r;
    logic [AW-1:0] wptr_r;
    logic          drain_cnt_r;

    logic          busy_r;
    logic          done_r;
    logic          mpen_r;
    logic          wincnt_r;
    logic          wr_en_r;
    logic [AW-1:0] raddr0_r;
    logic [AW-1:0] raddr1_r;
    logic [AW-1:0] waddr_r;
    logic [BD-1:0] wdata_r;

    logic [DW-1:0] cfg_ow_s;
    logic [DW-1:0] cfg_oh_s;
    logic          start_ok_s;
    logic          last_col_s;
    logic          last_win_s;
    logic          capture_s;
    logic [AW-1:0] w_ext_s;
    logic [AW-1:0] w2_ext_s;
    logic [AW-1:0] bot_addr_s;
    logic [AW-1:0] next_top_s;

    assign busy   = busy_r;
    assign done   = done_r;
    assign raddr0 = raddr0_r;
    assign raddr1 = raddr1_r;
    assign mpen   = mpen_r;
    assign wincnt = wincnt_r;
    assign wr_en  = wr_en_r;
    assign waddr  = waddr_r;
    assign wdata  = wdata_r;

    // Window bookkeeping and running-pointer address arithmetic.
    always_comb begin
        cfg_ow_s   = {1'b0, cfg_w[DW-1:1]};
        cfg_oh_s   = {1'b0, cfg_h[DW-1:1]};
        start_ok_s = (cfg_ow_s != ZERO_D) && (cfg_oh_s != ZERO_D);
        last_col_s = (col_r == (ow_r - ONE_D));
        last_win_s = last_col_s && (row_r == (oh_r - ONE_D));
        w_ext_s    = {{(AW-DW){1'b0}}, w_r};
        w2_ext_s   = {{(AW-DW-1){1'b0}}, w_r, 1'b0};
        bot_addr_s = cur_top_r + w_ext_s;
        if (last_col_s) begin
            next_top_s = row_base_r + w2_ext_s;
        end else begin
            next_top_s = cur_top_r + TWO_A;
        end
        // The bottom pair of a window is in the compare unit during this cycle.
        capture_s  = mpen_r && wincnt_r;
    end

    // Next-state logic of the window sequencer.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nx_s = start_ok_s ? S_TOP : S_EMPTY;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_TOP:   state_nx_s = S_BOT;
            S_BOT: begin
                if (last_win_s) begin
                    state_nx_s = S_DRAIN;
                end else begin
                    state_nx_s = S_TOP;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_r) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_DRAIN;
                end
            end
            S_EMPTY: state_nx_s = S_IDLE;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // State register, address pointers and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            w_r         <= {DW{1'b0}};
            ow_r        <= {DW{1'b0}};
            oh_r        <= {DW{1'b0}};
            col_r       <= {DW{1'b0}};
            row_r       <= {DW{1'b0}};
            cur_top_r   <= {AW{1'b0}};
            row_base_r  <= {AW{1'b0}};
            wptr_r      <= {AW{1'b0}};
            drain_cnt_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            mpen_r      <= 1'b0;
            wincnt_r    <= 1'b0;
            wr_en_r     <= 1'b0;
            raddr0_r    <= {AW{1'b0}};
            raddr1_r    <= {AW{1'b0}};
            waddr_r     <= {AW{1'b0}};
            wdata_r     <= {BD{1'b0}};
        end else begin
            state_r  <= state_nx_s;
            busy_r   <= (state_nx_s != S_IDLE);
            done_r   <= (state_nx_s == S_EMPTY) || ((state_r == S_DRAIN) && !drain_cnt_r);
            // Compare-unit controls trail the address issue by the RAM latency.
            mpen_r   <= (state_r == S_TOP) || (state_r == S_BOT);
            wincnt_r <= (state_r == S_BOT);
            wr_en_r  <= capture_s;
            if (capture_s) begin
                wdata_r <= d;
                waddr_r <= wptr_r;
                wptr_r  <= wptr_r + ONE_A;
            end
            case (state_r)
                S_IDLE: begin
                    drain_cnt_r <= 1'b0;
                    if (start && start_ok_s) begin
                        w_r        <= cfg_w;
                        ow_r       <= cfg_ow_s;
                        oh_r       <= cfg_oh_s;
                        col_r      <= {DW{1'b0}};
                        row_r      <= {DW{1'b0}};
                        cur_top_r  <= cfg_src_base;
                        row_base_r <= cfg_src_base;
                        wptr_r     <= cfg_dst_base;
                        raddr0_r   <= cfg_src_base;
                        raddr1_r   <= cfg_src_base + ONE_A;
                    end
                end
                S_TOP: begin
                    raddr0_r <= bot_addr_s;
                    raddr1_r <= bot_addr_s + ONE_A;
                end
                S_BOT: begin
                    drain_cnt_r <= 1'b0;
                    if (!last_win_s) begin
                        cur_top_r <= next_top_s;
                        raddr0_r  <= next_top_s;
                        raddr1_r  <= next_top_s + ONE_A;
                        if (last_col_s) begin
                            row_base_r <= next_top_s;
                            col_r      <= {DW{1'b0}};
                            row_r      <= row_r + ONE_D;
                        end else begin
                            col_r <= col_r + ONE_D;
                        end
                    end
                end
                S_DRAIN: drain_cnt_r <= 1'b1;
                S_EMPTY: drain_cnt_r <= 1'b0;
                default: drain_cnt_r <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_ctrl.sv
// Bench for maxpool_ctrl: RAM + falling-edge compare-unit model, write/done scoreboard,
// and directed per-cycle checks of the read side.
module tb_maxpool_ctrl;
    localparam int BD = 18;
    localparam int AW = 12;
    localparam int DW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] cfg_w;
    logic [DW-1:0] cfg_h;
    logic [AW-1:0] cfg_src_base;
    logic [AW-1:0] cfg_dst_base;
    logic          busy;
    logic          done;
    logic [AW-1:0] raddr0;
    logic [AW-1:0] raddr1;
    logic          mpen;
    logic          wincnt;
    logic          wr_en;
    logic [AW-1:0] waddr;
    logic [BD-1:0] wdata;

    logic signed [BD-1:0] mem [0:(1<<AW)-1];
    logic signed [BD-1:0] q0;
    logic signed [BD-1:0] q1;
    logic signed [BD-1:0] d_m;

    typedef struct {
        logic [AW-1:0] addr;
        logic [BD-1:0] data;
        int            cyc;
    } wr_t;

    wr_t           wq[$];
    int            dq[$];
    wr_t           mon_e;
    int            mon_c;
    int            exp_ra[$];
    logic [BD-1:0] exp_wd[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            c0 = 0;

    maxpool_ctrl #(.BD(BD), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_w(cfg_w), .cfg_h(cfg_h),
        .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base),
        .busy(busy), .done(done), .raddr0(raddr0), .raddr1(raddr1),
        .mpen(mpen), .wincnt(wincnt), .d(d_m),
        .wr_en(wr_en), .waddr(waddr), .wdata(wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous dual-read RAM.
    always @(posedge clk) begin
        q0 <= mem[raddr0];
        q1 <= mem[raddr1];
    end

    function automatic logic signed [BD-1:0] smax(input logic signed [BD-1:0] a, input logic signed [BD-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Compare unit: first pair loads, second pair accumulates; updates on the falling edge.
    always @(negedge clk) begin
        if (mpen === 1'b1) begin
            if (wincnt == 1'b0) d_m <= smax(q0, q1);
            else                d_m <= smax(d_m, smax(q0, q1));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes or signals done.
    always @(posedge clk) begin
        #1;
        if (wr_en === 1'b1) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got waddr %0d in cycle %0d, required no write", waddr, cyc - c0);
            end else begin
                mon_e = wq.pop_front();
                check("waddr", 32'(waddr), 32'(mon_e.addr));
                check("wdata", 32'(wdata), 32'(mon_e.data));
                check("wr_cycle", 32'(cyc - c0), 32'(mon_e.cyc - c0));
            end
        end
        if (done === 1'b1) begin
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done in cycle %0d, required none", cyc - c0);
            end else begin
                mon_c = dq.pop_front();
                check("done_cycle", 32'(cyc - c0), 32'(mon_c - c0));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   32'(busy),   32'd0);
        check({tag, "_done"},   32'(done),   32'd0);
        check({tag, "_mpen"},   32'(mpen),   32'd0);
        check({tag, "_wincnt"}, 32'(wincnt), 32'd0);
        check({tag, "_wr_en"},  32'(wr_en),  32'd0);
        check({tag, "_raddr0"}, 32'(raddr0), 32'd0);
        check({tag, "_raddr1"}, 32'(raddr1), 32'd0);
        check({tag, "_waddr"},  32'(waddr),  32'd0);
        check({tag, "_wdata"},  32'(wdata),  32'd0);
    endtask

    // One pass: exp_ra/exp_wd hold the hand-computed read addresses and window maxima.
    task automatic run_pass(input int w, input int h, input int src, input int dst,
                            input int nwin, input int abort_at, input bit disturb);
        int last;
        logic exp_busy;
        logic exp_mpen;
        step();
        cfg_w        = DW'(w);
        cfg_h        = DW'(h);
        cfg_src_base = AW'(src);
        cfg_dst_base = AW'(dst);
        start        = 1'b1;
        c0           = cyc;
        for (int k = 0; k < nwin; k++) begin
            if (abort_at == 0 || 4 + 2 * k <= abort_at)
                wq.push_back('{addr: AW'(dst + k), data: exp_wd[k], cyc: c0 + 4 + 2 * k});
        end
        if (abort_at == 0) dq.push_back((nwin == 0) ? c0 + 1 : c0 + 2 * nwin + 2);
        last = (nwin == 0) ? 3 : 2 * nwin + 3;
        step();
        start = 1'b0;
        for (int n = 1; n <= last; n++) begin
            if (abort_at != 0 && n == abort_at + 1) begin
                check_all_zero("abort");
                reset = 1'b0;
                return;
            end
            if (disturb && n == 1) begin
                start        = 1'b1;
                cfg_w        = DW'(w + 2);
                cfg_src_base = AW'(src + 8);
                cfg_dst_base = AW'(dst + 8);
            end
            if (disturb && n == 2) start = 1'b0;
            exp_busy = (nwin == 0) ? (n == 1) : (n <= 2 * nwin + 2);
            exp_mpen = (nwin > 0) && (n >= 2) && (n <= 2 * nwin + 1);
            check("busy", 32'(busy), 32'(exp_busy));
            check("mpen", 32'(mpen), 32'(exp_mpen));
            if (exp_mpen) check("wincnt", 32'(wincnt), 32'((n - 2) % 2));
            if (nwin > 0 && n <= 2 * nwin) begin
                check("raddr0", 32'(raddr0), 32'(exp_ra[n - 1]));
                check("raddr1", 32'(raddr1), 32'((exp_ra[n - 1] + 1) % (1 << AW)));
            end
            if (abort_at != 0 && n == abort_at) reset = 1'b1;
            step();
        end
    endtask

    int init_v[16] = '{3, -7, 10, 2, -1, 5, -4, -9, -5, -3, 0, -1, -7, -1, 2, 1};

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        cfg_w        = {DW{1'b0}};
        cfg_h        = {DW{1'b0}};
        cfg_src_base = {AW{1'b0}};
        cfg_dst_base = {AW{1'b0}};
        for (int i = 0; i < (1 << AW); i++) mem[i] = {BD{1'b0}};
        for (int i = 0; i < 16; i++) mem[i] = BD'(init_v[i]);
        mem[4094] = 18'sd7;
        mem[4095] = -18'sd2;

        repeat (3) step();
        check_all_zero("reset");
        reset = 1'b0;
        step();
        check_all_zero("idle");

        // 4x4 map: maxima 5, 10, -1, 2 written back-to-back.
        exp_ra = '{0, 4, 2, 6, 8, 12, 10, 14};
        exp_wd = '{18'd5, 18'd10, 18'h3FFFF, 18'd2};
        run_pass(4, 4, 0, 100, 4, 0, 1'b0);

        // 5x3 map: odd column and row dropped.
        exp_ra = '{0, 5, 2, 7};
        exp_wd = '{18'd5, 18'd10};
        run_pass(5, 3, 0, 200, 2, 0, 1'b0);

        // Degenerate width: no windows.
        run_pass(1, 4, 0, 300, 0, 0, 1'b0);

        // Reset during cycle 5, then a clean rerun of the 4x4 pass.
        exp_ra = '{0, 4, 2, 6, 8, 12, 10, 14};
        exp_wd = '{18'd5, 18'd10, 18'h3FFFF, 18'd2};
        run_pass(4, 4, 0, 100, 4, 5, 1'b0);
        run_pass(4, 4, 0, 100, 4, 0, 1'b0);

        // Address wrap at the top of memory, with start/config disturbed mid-pass.
        exp_ra = '{4094, 0};
        exp_wd = '{18'd7};
        run_pass(2, 2, 4094, 50, 1, 0, 1'b1);

        repeat (4) step();
        check("pending_writes", 32'(wq.size()), 32'd0);
        check("pending_done", 32'(dq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
